// File: rtl/riscv_test_monitor.sv
// Self-checking monitor for a RISC-V core run: compares OUTPUT_PORT against a
// table of expected results at given retired-instruction counts.
module riscv_test_monitor #(
    parameter int unsigned NUM_TEST     = 32,
    parameter int unsigned IDX_W        = 5,
    parameter int unsigned DWIDTH       = 32,
    parameter bit          STOP_ON_FAIL = 1'b1,
    parameter int unsigned TIMEOUT      = 1000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CFG_WE,
    input  logic [IDX_W-1:0]  CFG_IDX,
    input  logic [DWIDTH-1:0] CFG_NUM_INST,
    input  logic [DWIDTH-1:0] CFG_ANS,
    input  logic [IDX_W:0]    CFG_CNT,
    input  logic              START,
    input  logic [DWIDTH-1:0] NUM_INST,
    input  logic [DWIDTH-1:0] OUTPUT_PORT,
    input  logic              HALT,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic              TIMED_OUT,
    output logic [IDX_W:0]    PASS_CNT,
    output logic [IDX_W:0]    FAIL_CNT,
    output logic [IDX_W-1:0]  FAIL_IDX,
    output logic [DWIDTH-1:0] FAIL_GOT,
    output logic [DWIDTH-1:0] CYCLE
);

    localparam int unsigned       CNT_W   = IDX_W + 1;
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(NUM_TEST);
    localparam logic [DWIDTH-1:0] TO_LAST = DWIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    typedef struct packed {
        logic [DWIDTH-1:0] num_inst;
        logic [DWIDTH-1:0] ans;
    } entry_t;

    entry_t             tbl_q [NUM_TEST];
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cfg_cnt_clamped;
    entry_t             cur_entry;
    logic               hit;

    logic               busy_d, done_d, pass_d, timed_out_d;
    logic [CNT_W-1:0]   pass_cnt_d, fail_cnt_d;
    logic [IDX_W-1:0]   fail_idx_d;
    logic [DWIDTH-1:0]  fail_got_d, cycle_d;
    logic               mismatch, reached, stop, tmo;

    // Expected-result table: writable only outside a run, never reset
    always_ff @(posedge CLK) begin
        if (!RST && CFG_WE && state_q != RUN && CNT_W'(CFG_IDX) < MAX_CNT) begin
            tbl_q[CFG_IDX] <= '{num_inst: CFG_NUM_INST, ans: CFG_ANS};
        end
    end

    assign cfg_cnt_clamped = (CFG_CNT > MAX_CNT) ? MAX_CNT : CFG_CNT;
    assign cur_entry       = tbl_q[ptr_q[IDX_W-1:0]];
    assign hit             = (ptr_q < cnt_q) && (NUM_INST == cur_entry.num_inst);

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        busy_d      = BUSY;
        done_d      = DONE;
        pass_d      = PASS;
        timed_out_d = TIMED_OUT;
        pass_cnt_d  = PASS_CNT;
        fail_cnt_d  = FAIL_CNT;
        fail_idx_d  = FAIL_IDX;
        fail_got_d  = FAIL_GOT;
        cycle_d     = CYCLE;
        mismatch    = 1'b0;
        reached     = 1'b0;
        stop        = 1'b0;
        tmo         = 1'b0;

        if (START) begin
            state_d     = RUN;
            cnt_d       = cfg_cnt_clamped;
            ptr_d       = '0;
            busy_d      = 1'b1;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            timed_out_d = 1'b0;
            pass_cnt_d  = '0;
            fail_cnt_d  = '0;
            fail_idx_d  = '0;
            fail_got_d  = '0;
            cycle_d     = '0;
        end else if (state_q == RUN) begin
            cycle_d = (CYCLE == '1) ? CYCLE : CYCLE + DWIDTH'(1);
            if (hit) begin
                ptr_d   = ptr_q + CNT_W'(1);
                reached = (ptr_d == cnt_q);
                if (OUTPUT_PORT == cur_entry.ans) begin
                    pass_cnt_d = PASS_CNT + CNT_W'(1);
                end else begin
                    mismatch   = 1'b1;
                    fail_cnt_d = FAIL_CNT + CNT_W'(1);
                    if (FAIL_CNT == '0) begin
                        fail_idx_d = ptr_q[IDX_W-1:0];
                        fail_got_d = OUTPUT_PORT;
                    end
                end
            end
            // Timeout only claims the ending when nothing stronger fired
            stop = (STOP_ON_FAIL && mismatch) || HALT || reached;
            tmo  = !stop && (cycle_d == TO_LAST);
            if (stop || tmo) begin
                state_d     = FIN;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                timed_out_d = tmo;
                pass_d      = (fail_cnt_d == '0) && !tmo && (ptr_d == cnt_q);
            end
        end
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            TIMED_OUT <= 1'b0;
            PASS_CNT  <= '0;
            FAIL_CNT  <= '0;
            FAIL_IDX  <= '0;
            FAIL_GOT  <= '0;
            CYCLE     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            BUSY      <= busy_d;
            DONE      <= done_d;
            PASS      <= pass_d;
            TIMED_OUT <= timed_out_d;
            PASS_CNT  <= pass_cnt_d;
            FAIL_CNT  <= fail_cnt_d;
            FAIL_IDX  <= fail_idx_d;
            FAIL_GOT  <= fail_got_d;
            CYCLE     <= cycle_d;
        end
    end

endmodule

// File: doc/riscv_test_monitor.md
RISCV_TEST_MONITOR -- requirements
Module: riscv_test_monitor

Interface
REQ-001 The block SHALL have one clock and synchronous active-high reset; all state SHALL update on the rising edge of CLK.
REQ-002 Parameter NUM_TEST, default 32: expected-result table depth.
REQ-003 Parameter IDX_W, default 5: table index width, equal to clog2(NUM_TEST).
REQ-004 Parameter DWIDTH, default 32: width of instruction count and result data.
REQ-005 Parameter STOP_ON_FAIL, default 1: 1 = end the run at the first mismatch; 0 = count mismatches and continue.
REQ-006 Parameter TIMEOUT, default 1000000: cycle limit for a run.
REQ-007 Port CLK  in  1: clock.
REQ-008 Port RST  in  1: synchronous reset, active-high.
REQ-009 Port CFG_WE  in  1: table write strobe.
REQ-010 Port CFG_IDX  in  IDX_W: table write index.
REQ-011 Port CFG_NUM_INST  in  DWIDTH: instruction count at which an entry is checked.
REQ-012 Port CFG_ANS  in  DWIDTH: expected OUTPUT_PORT value for that entry.
REQ-013 Port CFG_CNT  in  IDX_W+1: number of valid entries, sampled at START.
REQ-014 Port START  in  1: begin a run.
REQ-015 Port NUM_INST  in  DWIDTH: retired-instruction count from the core.
REQ-016 Port OUTPUT_PORT  in  DWIDTH: core result value.
REQ-017 Port HALT  in  1: core halt flag.
REQ-018 Port BUSY  out  1: high while a run is in progress.
REQ-019 Port DONE  out  1: run finished; held until the next START.
REQ-020 Port PASS  out  1: qualified by DONE.
REQ-021 Port TIMED_OUT  out  1: run ended on the cycle limit.
REQ-022 Port PASS_CNT  out  IDX_W+1: number of passed checks.
REQ-023 Port FAIL_CNT  out  IDX_W+1: number of failed checks.
REQ-024 Port FAIL_IDX  out  IDX_W: index of the first failing entry.
REQ-025 Port FAIL_GOT  out  DWIDTH: OUTPUT_PORT value at the first failure.
REQ-026 Port CYCLE  out  DWIDTH: cycles counted in RUN.

Function
REQ-027 FSM states SHALL be IDLE, RUN, FIN.
- IDLE -> RUN on START.
- RUN -> FIN on end condition.
- FIN -> RUN on START.
REQ-028 CFG_WE SHALL write {CFG_NUM_INST, CFG_ANS} to entry CFG_IDX in IDLE or FIN; CFG_WE SHALL be ignored in RUN.
REQ-029 On START the block SHALL:
- latch CFG_CNT as cnt;
- clear ptr, PASS_CNT, FAIL_CNT, CYCLE, FAIL_IDX, FAIL_GOT, TIMED_OUT and DONE;
- set BUSY the next cycle.
REQ-030 Entries SHALL be checked in index order via pointer ptr; entry NUM_INST values are required to be strictly ascending.
REQ-031 Check rule: in RUN, when ptr < cnt and NUM_INST == entry[ptr].num_inst, the block SHALL compare OUTPUT_PORT with entry[ptr].ans in that cycle and increment ptr by one.
REQ-032 On a match, PASS_CNT SHALL increment.
REQ-033 On a mismatch, FAIL_CNT SHALL increment; on the first mismatch FAIL_IDX := ptr and FAIL_GOT := OUTPUT_PORT.
REQ-034 At most one entry SHALL be checked per cycle; a repeated NUM_INST value on later cycles SHALL NOT re-check the same entry.
REQ-035 CYCLE SHALL increment every RUN cycle and saturate at all-ones.
REQ-036 End conditions, evaluated after any same-cycle check:
- (a) mismatch with STOP_ON_FAIL=1;
- (b) ptr reaches cnt;
- (c) HALT=1;
- (d) CYCLE == TIMEOUT-1, which sets TIMED_OUT.
REQ-037 Priority when end conditions coincide: the check result is recorded first, then (a) > (c) > (b) > (d).
REQ-038 On entering FIN: DONE=1, BUSY=0, PASS = (FAIL_CNT==0) && !TIMED_OUT && (ptr==cnt).
REQ-039 HALT before all entries are checked SHALL give PASS=0.
REQ-040 cnt=0 SHALL end the run at the next HALT or timeout; PASS=1 only on HALT.
REQ-041 cnt > NUM_TEST SHALL be clamped to NUM_TEST.
REQ-042 START while in RUN SHALL restart the run (same behaviour as REQ-029).
REQ-043 Outputs SHALL be registered; DONE/PASS SHALL be valid the cycle after the ending event.

Reset
REQ-044 RST SHALL force IDLE and clear BUSY, DONE, PASS, TIMED_OUT, PASS_CNT, FAIL_CNT, FAIL_IDX, FAIL_GOT, CYCLE, ptr and cnt; table contents are undefined after reset.
REQ-045 RST asserted mid-run SHALL abort the run with no DONE pulse; RST SHALL take priority over START and CFG_WE.

Verification
REQ-046 Load 3 entries {(1,0),(2,0),(3,5)}, cnt=3, drive NUM_INST 1..3 with OUTPUT_PORT 0,0,5 -> PASS_CNT=3, DONE=1, PASS=1 one cycle after NUM_INST=3.
REQ-047 STOP_ON_FAIL=1, entry 2 expects 0x5, core gives 0x4 -> DONE=1, PASS=0, FAIL_IDX=2, FAIL_GOT=0x4, later entries unchecked.
REQ-048 STOP_ON_FAIL=0, 4 entries with entries 1 and 3 wrong -> run continues, FAIL_CNT=2, PASS_CNT=2, FAIL_IDX=1, PASS=0.
REQ-049 HALT in the same cycle as the last matching check -> PASS_CNT=cnt, PASS=1; HALT one entry early -> PASS=0.
REQ-050 TIMEOUT=16, NUM_INST stuck -> DONE at CYCLE=15, TIMED_OUT=1, PASS=0.
REQ-051 RST mid-run, then reload and START -> all counters 0, and the fresh run passes independently.
